// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: merges ALU and LSU results onto the single regfile write port.
// Each source has its own small FIFO with a valid/ready handshake. A round-robin
// arbiter drains the FIFOs into a registered write port, so at most one write
// retires per cycle.
module regfile_wb_arbiter #(
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned REG_COUNT  = 32,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  alu_valid,
  output logic                                  alu_ready,
  input  logic [$clog2(REG_COUNT)-1:0]          alu_addr,
  input  logic [DATA_W-1:0]                     alu_data,
  input  logic                                  lsu_valid,
  output logic                                  lsu_ready,
  input  logic [$clog2(REG_COUNT)-1:0]          lsu_addr,
  input  logic [DATA_W-1:0]                     lsu_data,
  output logic                                  wr_en,
  output logic [$clog2(REG_COUNT)-1:0]          wr1_addr,
  output logic [DATA_W-1:0]                     wr1_data,
  output logic [$clog2(2*FIFO_DEPTH+2)-1:0]     pending,
  output logic                                  idle
);

  localparam int unsigned ADDR_W = $clog2(REG_COUNT);
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PEND_W = $clog2(2 * FIFO_DEPTH + 2);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LSU = 1'b1
  } src_e;

  // Index 0 is the ALU FIFO, index 1 the LSU FIFO.
  logic [ADDR_W-1:0] addr_mem [2][FIFO_DEPTH];
  logic [DATA_W-1:0] data_mem [2][FIFO_DEPTH];
  logic [PTR_W-1:0]  wptr     [2];
  logic [PTR_W-1:0]  rptr     [2];
  logic [CNT_W-1:0]  count    [2];

  logic [ADDR_W-1:0] in_addr  [2];
  logic [DATA_W-1:0] in_data  [2];
  logic [1:0]        in_valid;
  logic [1:0]        full;
  logic [1:0]        nonempty;
  logic [1:0]        push;
  logic [1:0]        pop;

  src_e              rr_ptr;
  src_e              rr_next;
  logic              sel_idx;
  logic              pop_any;
  logic [ADDR_W-1:0] pop_addr;
  logic [DATA_W-1:0] pop_data;

  // Gather the two source interfaces into indexable form.
  always_comb begin
    in_valid   = {lsu_valid, alu_valid};
    in_addr[0] = alu_addr;
    in_addr[1] = lsu_addr;
    in_data[0] = alu_data;
    in_data[1] = lsu_data;
  end

  // FIFO status; ready depends only on occupancy, so a full FIFO stays not-ready
  // even in a cycle where it is being popped.
  always_comb begin
    full     = '0;
    nonempty = '0;
    push     = '0;
    for (int unsigned s = 0; s < 2; s++) begin
      full[s]     = (count[s] == FULL_CNT);
      nonempty[s] = (count[s] != '0);
      push[s]     = in_valid[s] && !full[s];
    end
  end

  assign alu_ready = !full[0];
  assign lsu_ready = !full[1];

  // Round-robin grant: the pointer only matters, and only advances, when both contend.
  always_comb begin
    rr_next = rr_ptr;
    sel_idx = 1'b0;
    pop     = '0;
    if (&nonempty) begin
      sel_idx = (rr_ptr == SRC_LSU);
      rr_next = (rr_ptr == SRC_ALU) ? SRC_LSU : SRC_ALU;
    end else if (nonempty[1]) begin
      sel_idx = 1'b1;
    end
    pop_any = |nonempty;
    if (pop_any) begin
      if (sel_idx) pop[1] = 1'b1;
      else         pop[0] = 1'b1;
    end
    pop_addr = addr_mem[sel_idx][rptr[sel_idx]];
    pop_data = data_mem[sel_idx][rptr[sel_idx]];
  end

  // FIFO storage; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    for (int unsigned s = 0; s < 2; s++) begin
      if (push[s]) begin
        addr_mem[s][wptr[s]] <= in_addr[s];
        data_mem[s][wptr[s]] <= in_data[s];
      end
    end
  end

  // FIFO pointers and occupancy; a simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk) begin
    for (int unsigned s = 0; s < 2; s++) begin
      if (!rst) begin
        wptr[s]  <= '0;
        rptr[s]  <= '0;
        count[s] <= '0;
      end else begin
        if (push[s]) wptr[s] <= wptr[s] + PTR_W'(1);
        if (pop[s])  rptr[s] <= rptr[s] + PTR_W'(1);
        count[s] <= count[s] + CNT_W'(push[s]) - CNT_W'(pop[s]);
      end
    end
  end

  // Arbiter pointer register.
  always_ff @(posedge clk) begin
    if (!rst) rr_ptr <= SRC_ALU;
    else      rr_ptr <= rr_next;
  end

  // Registered regfile write port; address/data hold when no write retires.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_en    <= 1'b0;
      wr1_addr <= '0;
      wr1_data <= '0;
    end else begin
      wr_en <= pop_any;
      if (pop_any) begin
        wr1_addr <= pop_addr;
        wr1_data <= pop_data;
      end
    end
  end

  assign pending = PEND_W'(count[0]) + PEND_W'(count[1]) + PEND_W'(wr_en);
  assign idle    = (pending == '0);

endmodule
